rx_point_test_cmp: RTL
======================

// Module: rx_point_test_cmp
// PURPOSE
//  Receiver-side point-test compare engine feeding the MBTRAIN RX calibration FSMs (vref/deskew cal).
//  Enabled by the cal FSM's pt_en; compares per-lane received bits to a locally generated expected pattern
//  (PRBS23 for mainband, 11110000 for valtrain), counts errors per lane, then returns a per-lane pass vector and test ack.
// PARAMETERS
//  NUM_LANES   16        number of receive lanes (one bit per lane per clk)
//  ERR_W       16        per-lane error counter width (saturating)
//  ITER_W      16        width of compare-length input
//  PRBS_SEED   23'h1DBFBC  PRBS23 seed loaded for every lane at test start
// PORTS
//  clk                     in   1          clock
//  rst_n                   in   1          asynchronous reset, active-low
//  i_en                    in   1          point-test enable (cal FSM pt_en); low = abort/return to IDLE
//  i_mainband_or_valtrain  in   1          0 = PRBS23 mainband pattern, 1 = valtrain 11110000 pattern
//  i_iter_count            in   ITER_W     number of valid bits to compare per lane
//  i_err_threshold         in   ERR_W      max errors per lane still counted as pass
//  i_lane_mask             in   NUM_LANES  1 = lane participates
//  i_data_valid            in   1          i_lane_data valid this cycle
//  i_lane_data             in   NUM_LANES  received bit per lane
//  o_rx_lanes_result       out  NUM_LANES  1 = lane passed; valid while o_test_ack high
//  o_test_ack              out  1          compare complete; held high until i_en low
//  o_busy                  out  1          high in LOAD/COMPARE/EVAL
// BEHAVIOUR
//  Reset: all outputs 0, counters 0, LFSR = PRBS_SEED, state IDLE.
//  FSM: IDLE -(i_en)-> LOAD -> COMPARE -(bit_cnt==i_iter_count)-> EVAL -> DONE -(~i_en)-> IDLE.
//   LOAD (1 cycle): clear err counters and bit_cnt, load LFSR seed, latch mode/threshold/mask/iter_count.
//   i_iter_count==0 latched: LOAD -> EVAL directly; every unmasked lane passes (err=0).
//  Compare: only on i_data_valid in COMPARE; expected bit = LFSR[22] (mainband) or pattern[7-phase] (valtrain);
//   LFSR/phase advance only on valid. PRBS23 poly x^23+x^21+x^18+x^15+x^7+x^2+1, Fibonacci, MSB-out.
//   mismatch on unmasked lane -> err_cnt+1, saturating at 2^ERR_W-1; bit_cnt increments per valid.
//  Latency: valid bit k (k=i_iter_count) sampled at edge N -> state EVAL at N+1;
//   o_rx_lanes_result and o_test_ack registered high at N+2.
//  EVAL: result[i] = mask[i] && (err_cnt[i] <= threshold); masked lanes report 0.
//  DONE: results and ack held stable; inputs ignored; i_data_valid ignored.
//  i_en low in any state: next edge -> IDLE, ack/results/busy cleared, counters cleared (mid-test abort).
//  i_en re-asserted in same cycle as DONE->IDLE: new test begins via LOAD next cycle (no stale ack).
//  Input changes to i_iter_count/threshold/mask/mode after LOAD have no effect until next test.
//  i_data_valid gaps during COMPARE are legal; no timeout inside block (cal FSM owns timeout).
// CONFIGURATION
//  Macro PT_ERR_CNT_OUT_EN:
//   defined   -> extra ports o_lane_err_cnt [NUM_LANES*ERR_W-1:0] (lane i at [i*ERR_W+:ERR_W]) and
//                o_total_err_cnt [ERR_W+4-1:0] (sum of unmasked lane counts, registered in EVAL, valid with ack).
//   undefined -> ports absent; counters internal only; no adder tree synthesised.
// STRUCTURE
//  Package ucie_pt_pkg: state encoding constants, PRBS23 poly taps, default seed, VALTRAIN_PATTERN=8'b11110000.
//  Sub-module pt_pattern_gen: PRBS23 LFSR + 3-bit valtrain phase counter; ports load, advance, mode, exp_bit.
//  Top holds FSM, bit counter, NUM_LANES saturating error counters (generate loop), evaluation register.
// TESTING
//  T1 mainband, iter=1000, thr=0, all lanes fed exact PRBS23 -> result=16'hFFFF, ack 2 cycles after last valid.
//  T2 valtrain, iter=64, thr=3, lane5 flipped 4 times, lane9 3 times -> result=16'hFFDF.
//  T3 mask=16'h00FF, lanes 8-15 driven random -> result=16'h00FF; with PT_ERR_CNT_OUT_EN total=0.
//  T4 iter=0 -> ack 2 cycles after i_en, result=mask; i_data_valid ignored.
//  T5 i_en dropped at bit 500 of 1000 -> IDLE next edge, ack/result 0; re-enable runs clean full test.
//  T6 ERR_W=4 build, lane0 inverted 100 bits, thr=15 -> counter saturates at 15, lane0 passes; gaps in valid tolerated.

Source files
------------

// File: rtl/ucie_pt_pkg.sv
// Shared definitions for the RX point-test compare engine: FSM state
// encoding, PRBS23 generator constants and the valtrain pattern.
package ucie_pt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COMPARE = 3'd2,
        ST_EVAL    = 3'd3,
        ST_DONE    = 3'd4
    } pt_state_e;

    // x^23 + x^21 + x^18 + x^15 + x^7 + x^2 + 1 -> tap bits 22,20,17,14,6,1
    localparam logic [22:0] PRBS23_TAPS        = 23'h524042;
    localparam logic [22:0] PRBS_DEFAULT_SEED  = 23'h1DBFBC;
    localparam logic [7:0]  VALTRAIN_PATTERN   = 8'b11110000;

    // Fibonacci step: shift towards the MSB (which is the output bit),
    // feed the XOR of the tap bits into the LSB.
    function automatic logic [22:0] prbs23_next(input logic [22:0] s);
        return {s[21:0], ^(s & PRBS23_TAPS)};
    endfunction

endpackage

// File: rtl/pt_pattern_gen.sv
// Expected-bit generator: PRBS23 LFSR for mainband, 3-bit phase counter
// walking the 11110000 valtrain pattern. Both advance only on advance_i.
module pt_pattern_gen
    import ucie_pt_pkg::*;
#(
    parameter logic [22:0] SEED = PRBS_DEFAULT_SEED
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic advance_i,
    input  logic mode_i,
    output logic exp_bit_o
);

    logic [22:0] lfsr_q;
    logic [2:0]  phase_q;

    // Seed on load, step both generators on every valid received bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q  <= SEED;
            phase_q <= 3'd0;
        end else if (load_i) begin
            lfsr_q  <= SEED;
            phase_q <= 3'd0;
        end else if (advance_i) begin
            lfsr_q  <= prbs23_next(lfsr_q);
            phase_q <= phase_q + 3'd1;
        end
    end

    assign exp_bit_o = mode_i ? VALTRAIN_PATTERN[3'd7 - phase_q] : lfsr_q[22];

endmodule

// File: rtl/rx_point_test_cmp.sv
// RX point-test compare engine: compares each lane's received bit stream to
// the locally generated pattern, counts per-lane errors (saturating) and
// reports a per-lane pass vector with a held test acknowledge.
// Optional macro PT_ERR_CNT_OUT_EN exposes per-lane and total error counts.
module rx_point_test_cmp
    import ucie_pt_pkg::*;
#(
    parameter int          NUM_LANES = 16,
    parameter int          ERR_W     = 16,
    parameter int          ITER_W    = 16,
    parameter logic [22:0] PRBS_SEED = PRBS_DEFAULT_SEED
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_en,
    input  logic                 i_mainband_or_valtrain,
    input  logic [ITER_W-1:0]    i_iter_count,
    input  logic [ERR_W-1:0]     i_err_threshold,
    input  logic [NUM_LANES-1:0] i_lane_mask,
    input  logic                 i_data_valid,
    input  logic [NUM_LANES-1:0] i_lane_data,
    output logic [NUM_LANES-1:0] o_rx_lanes_result,
    output logic                 o_test_ack,
    output logic                 o_busy
`ifdef PT_ERR_CNT_OUT_EN
    ,
    output logic [NUM_LANES*ERR_W-1:0] o_lane_err_cnt,
    output logic [ERR_W+4-1:0]         o_total_err_cnt
`endif
);

    pt_state_e              state_q, state_d;
    logic [ITER_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [ITER_W-1:0]      iter_q;
    logic [ERR_W-1:0]       thr_q;
    logic [NUM_LANES-1:0]   mask_q;
    logic                   mode_q;
    logic [NUM_LANES-1:0]   result_q;
    logic                   ack_q;
    logic [ERR_W-1:0]       err_cnt_q [NUM_LANES];
    logic [ERR_W-1:0]       err_cnt_d [NUM_LANES];
    logic [NUM_LANES-1:0]   pass_vec;

    logic in_load;
    logic do_cmp;
    logic cnt_clear;
    logic exp_bit;

    assign in_load   = (state_q == ST_LOAD);
    assign do_cmp    = (state_q == ST_COMPARE) && i_data_valid && (bit_cnt_q != iter_q);
    assign cnt_clear = !i_en || in_load;

    pt_pattern_gen #(.SEED(PRBS_SEED)) u_pattern_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (in_load),
        .advance_i (do_cmp),
        .mode_i    (mode_q),
        .exp_bit_o (exp_bit)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and bit-count logic; dropping i_en aborts from any state.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        if (!i_en) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE:    state_d = ST_LOAD;
                ST_LOAD: begin
                    bit_cnt_d = '0;
                    state_d   = (i_iter_count == '0) ? ST_EVAL : ST_COMPARE;
                end
                ST_COMPARE: begin
                    if (bit_cnt_q == iter_q) state_d = ST_EVAL;
                    else if (do_cmp)         bit_cnt_d = bit_cnt_q + ITER_W'(1);
                end
                ST_EVAL:    state_d = ST_DONE;
                ST_DONE:    state_d = ST_DONE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // Per-lane saturating error counters and pass decision.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic mismatch;
        assign mismatch = do_cmp && mask_q[g] && (i_lane_data[g] ^ exp_bit);
        assign err_cnt_d[g] = cnt_clear ? '0 :
                              (mismatch && (err_cnt_q[g] != '1)) ? err_cnt_q[g] + ERR_W'(1) :
                              err_cnt_q[g];
        assign pass_vec[g] = mask_q[g] && (err_cnt_q[g] <= thr_q);
`ifdef PT_ERR_CNT_OUT_EN
        assign o_lane_err_cnt[g*ERR_W +: ERR_W] = err_cnt_q[g];
`endif
    end

    // Error counter array.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the counters are plain flops, not a RAM, so they take the async reset like any register.
        if (!rst_n) begin
            for (int i = 0; i < NUM_LANES; i++) err_cnt_q[i] <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    // Test configuration latch, bit counter, result and acknowledge registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) begin
            bit_cnt_q <= '0;
            iter_q    <= '0;
            thr_q     <= '0;
            mask_q    <= '0;
            mode_q    <= 1'b0;
            result_q  <= '0;
            ack_q     <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            if (!i_en) begin
                result_q <= '0;
                ack_q    <= 1'b0;
            end else if (in_load) begin
                iter_q <= i_iter_count;
                thr_q  <= i_err_threshold;
                mask_q <= i_lane_mask;
                mode_q <= i_mainband_or_valtrain;
            end else if (state_q == ST_EVAL) begin
                result_q <= pass_vec;
                ack_q    <= 1'b1;
            end
        end
    end

`ifdef PT_ERR_CNT_OUT_EN
    logic [ERR_W+4-1:0] total_sum;
    logic [ERR_W+4-1:0] total_q;

    // Sum of unmasked lane counts.
    always_comb begin
        total_sum = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (mask_q[i]) total_sum = total_sum + (ERR_W+4)'(err_cnt_q[i]);
        end
    end

    // Total is captured alongside the result so it is valid with ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  total_q <= '0;
        else if (!i_en)              total_q <= '0;
        else if (state_q == ST_EVAL) total_q <= total_sum;
    end

    assign o_total_err_cnt = total_q;
`endif

    assign o_rx_lanes_result = result_q;
    assign o_test_ack        = ack_q;
    assign o_busy            = (state_q == ST_LOAD) || (state_q == ST_COMPARE) || (state_q == ST_EVAL);

endmodule
